// File: rtl/wb_regfile_pkg.sv
// Shared pipeline-register types and load-decode constants for the RV32 writeback stage.
package wb_regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Populated by the data-memory stage; consumed one-for-one by writeback.
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic              reg_write;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] final_out;
    logic              mem_to_reg;
    logic [2:0]        funct3;
    logic [1:0]        byte_off;
  } wback_state_t;

endpackage

// File: rtl/wb_regfile_load_ext.sv
// Load-lane extraction and sign/zero extension with alignment check; purely combinational.
module load_ext
  import wb_regfile_pkg::*;
#(
  parameter int XLEN = DATA_W
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] value,
  output logic            misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[8*byte_off +: 8];
  assign half_sel = word[16*byte_off[1] +: 16];

  always_comb begin
    value    = word;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  value = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: value = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        value    = {{(XLEN-16){half_sel[15]}}, half_sel};
        misalign = byte_off[0];
      end
      F3_LHU: begin
        value    = {{(XLEN-16){1'b0}}, half_sel};
        misalign = byte_off[0];
      end
      // LW and any unrecognised encoding behave as a full-word load.
      default: misalign = (byte_off != 2'd0);
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// RV32 writeback stage: load extension, register-file commit, bypassed read ports,
// retired-instruction counter and misaligned-load reporting.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN      = DATA_W,
  parameter int NREGS     = 32,
  parameter int CNT_WIDTH = 64,
  parameter bit BYPASS    = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  wback_state_t         i_wback_state,
  input  logic [ADDR_W-1:0]    i_rs1_addr,
  input  logic [ADDR_W-1:0]    i_rs2_addr,
  output logic [XLEN-1:0]      o_rs1_data,
  output logic [XLEN-1:0]      o_rs2_data,
  output logic                 o_fwd_wen,
  output logic [ADDR_W-1:0]    o_fwd_rd,
  output logic [XLEN-1:0]      o_fwd_data,
  output logic [CNT_WIDTH-1:0] o_instret,
  output logic                 o_misalign,
  output logic [XLEN-1:0]      o_misalign_pc
);

  logic [XLEN-1:0]      regs_reg [NREGS];
  logic [CNT_WIDTH-1:0] instret_reg;
  logic [XLEN-1:0]      misalign_pc_reg;

  logic [XLEN-1:0] ld_value;
  logic            ld_misalign;
  logic            misalign;
  logic            commit;
  logic [XLEN-1:0] wb_value;

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .funct3   (i_wback_state.funct3),
    .byte_off (i_wback_state.byte_off),
    .word     (i_wback_state.final_out),
    .value    (ld_value),
    .misalign (ld_misalign)
  );

  assign misalign = i_valid & i_wback_state.mem_to_reg & ld_misalign;
  assign wb_value = i_wback_state.mem_to_reg ? ld_value : i_wback_state.final_out;
  assign commit   = i_valid & i_wback_state.reg_write
                  & (i_wback_state.rd != '0) & ~misalign;

  // x0 is never written because commit excludes rd==0, so it stays at its reset zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else if (commit) begin
      regs_reg[i_wback_state.rd] <= wb_value;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      instret_reg     <= '0;
      misalign_pc_reg <= '0;
    end else begin
      if (i_valid && !misalign) instret_reg <= instret_reg + 1'b1;
      if (misalign)             misalign_pc_reg <= i_wback_state.pc;
    end
  end

  logic [ADDR_W-1:0] rd_addr [2];
  logic [XLEN-1:0]   rd_data [2];

  assign rd_addr[0] = i_rs1_addr;
  assign rd_addr[1] = i_rs2_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      always_comb begin
        if (rd_addr[gi] == '0)
          rd_data[gi] = '0;
        else if (BYPASS && commit && (rd_addr[gi] == i_wback_state.rd))
          rd_data[gi] = wb_value;
        else
          rd_data[gi] = regs_reg[rd_addr[gi]];
      end
    end
  endgenerate

  assign o_rs1_data    = rd_data[0];
  assign o_rs2_data    = rd_data[1];
  assign o_fwd_wen     = commit;
  assign o_fwd_rd      = i_wback_state.rd;
  assign o_fwd_data    = wb_value;
  assign o_instret     = instret_reg;
  assign o_misalign    = misalign;
  assign o_misalign_pc = misalign_pc_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: one bypassing instance and one non-bypassing instance share stimulus.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic         i_clk;
  logic         i_reset;
  logic         i_valid;
  wback_state_t ws;
  logic [4:0]   rs1, rs2;

  logic [31:0] rs1_data, rs2_data, fwd_data, mpc;
  logic [4:0]  fwd_rd;
  logic        fwd_wen, mis;
  logic [63:0] instret;

  logic [31:0] nb_rs1_data, nb_rs2_data, nb_fwd_data, nb_mpc;
  logic [4:0]  nb_fwd_rd;
  logic        nb_fwd_wen, nb_mis;
  logic [63:0] nb_instret;

  int tests_run = 0;
  int failures  = 0;

  wb_regfile #(.BYPASS(1'b1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_wback_state(ws),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2), .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
    .o_fwd_wen(fwd_wen), .o_fwd_rd(fwd_rd), .o_fwd_data(fwd_data),
    .o_instret(instret), .o_misalign(mis), .o_misalign_pc(mpc)
  );

  wb_regfile #(.BYPASS(1'b0)) dut_nb (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_wback_state(ws),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2), .o_rs1_data(nb_rs1_data), .o_rs2_data(nb_rs2_data),
    .o_fwd_wen(nb_fwd_wen), .o_fwd_rd(nb_fwd_rd), .o_fwd_data(nb_fwd_data),
    .o_instret(nb_instret), .o_misalign(nb_mis), .o_misalign_pc(nb_mpc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Apply one writeback-stage transaction on the falling edge, settled before the next rise.
  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [31:0] val, input logic m2r, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] pc);
    @(negedge i_clk);
    i_valid      = v;
    ws.reg_write = rw;
    ws.rd        = rd;
    ws.final_out = val;
    ws.mem_to_reg = m2r;
    ws.funct3    = f3;
    ws.byte_off  = off;
    ws.pc        = pc;
    #1;
    $display("[TB] txn v=%0b rw=%0b rd=%0d val=%08h m2r=%0b f3=%0d off=%0d pc=%08h",
             v, rw, rd, val, m2r, f3, off, pc);
  endtask

  // Cross the rising edge, then return the stage to a bubble.
  task automatic step_to_bubble();
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    ws = '0;
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_valid = 1'b0; ws = '0; rs1 = 5'd5; rs2 = 5'd7;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    #1;
    tests_run++;
    if (instret !== 64'd0) begin failures++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    tests_run++;
    if (mpc !== 32'd0) begin failures++; $display("FAIL reset_mpc got=%08h exp=0", mpc); end
    tests_run++;
    if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      failures++; $display("FAIL reset_regs got=%08h/%08h exp=0/0", rs1_data, rs2_data);
    end
  endtask

  task automatic test_alu_write();
    rs1 = 5'd5;
    drive(1, 1, 5'd5, 32'hDEADBEEF, 0, F3_LW, 2'd0, 32'h0);
    tests_run++;
    if (fwd_wen !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL alu_fwd got=%0b/%0d/%08h exp=1/5/deadbeef", fwd_wen, fwd_rd, fwd_data);
    end
    step_to_bubble();
    tests_run++;
    if (rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_x5 got=%08h exp=deadbeef", rs1_data); end
    tests_run++;
    if (instret !== 64'd1) begin failures++; $display("FAIL alu_instret got=%0d exp=1", instret); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [4] = '{F3_LB, F3_LBU, F3_LH, F3_LHU};
    logic [1:0]  offs [4] = '{2'd2, 2'd2, 2'd2, 2'd2};
    logic [31:0] ins  [4] = '{32'h0080_0000, 32'h0080_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000, 32'h0000_8000};
    rs1 = 5'd7;
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 5'd7, ins[k], 1, f3s[k], offs[k], 32'h40 + 32'(k));
      step_to_bubble();
      tests_run++;
      if (rs1_data !== exps[k]) begin
        failures++; $display("FAIL load_ext_%0d got=%08h exp=%08h", k, rs1_data, exps[k]);
      end
    end
    tests_run++;
    if (instret !== 64'd5) begin failures++; $display("FAIL load_instret got=%0d exp=5", instret); end
  endtask

  task automatic test_misalign();
    rs1 = 5'd8;
    drive(1, 1, 5'd8, 32'h1234_5678, 1, F3_LH, 2'd1, 32'h100);
    tests_run++;
    if (mis !== 1'b1 || fwd_wen !== 1'b0) begin
      failures++; $display("FAIL mis_lh_pulse got=%0b/%0b exp=1/0", mis, fwd_wen);
    end
    step_to_bubble();
    tests_run++;
    if (mpc !== 32'h100 || mis !== 1'b0) begin
      failures++; $display("FAIL mis_lh_pc got=%08h/%0b exp=00000100/0", mpc, mis);
    end
    tests_run++;
    if (rs1_data !== 32'd0 || instret !== 64'd5) begin
      failures++; $display("FAIL mis_lh_nowrite got=%08h/%0d exp=0/5", rs1_data, instret);
    end
    drive(1, 1, 5'd8, 32'h1234_5678, 1, F3_LW, 2'd2, 32'h200);
    step_to_bubble();
    tests_run++;
    if (mpc !== 32'h200 || rs1_data !== 32'd0 || instret !== 64'd5) begin
      failures++; $display("FAIL mis_lw got=%08h/%08h/%0d exp=00000200/0/5", mpc, rs1_data, instret);
    end
  endtask

  task automatic test_bypass();
    rs1 = 5'd3; rs2 = 5'd3;
    drive(1, 1, 5'd3, 32'h1234, 0, F3_LW, 2'd0, 32'h300);
    tests_run++;
    if (rs1_data !== 32'h1234 || rs2_data !== 32'h1234) begin
      failures++; $display("FAIL bypass_same got=%08h/%08h exp=1234/1234", rs1_data, rs2_data);
    end
    tests_run++;
    if (nb_rs1_data !== 32'd0 || nb_rs2_data !== 32'd0) begin
      failures++; $display("FAIL nobypass_same got=%08h/%08h exp=0/0", nb_rs1_data, nb_rs2_data);
    end
    step_to_bubble();
    tests_run++;
    if (rs1_data !== 32'h1234 || nb_rs2_data !== 32'h1234) begin
      failures++; $display("FAIL bypass_next got=%08h/%08h exp=1234/1234", rs1_data, nb_rs2_data);
    end
  endtask

  task automatic test_x0_and_bubble();
    rs1 = 5'd0; rs2 = 5'd4;
    drive(1, 1, 5'd0, 32'hFFFF_FFFF, 0, F3_LW, 2'd0, 32'h400);
    tests_run++;
    if (fwd_wen !== 1'b0 || rs1_data !== 32'd0) begin
      failures++; $display("FAIL x0_same got=%0b/%08h exp=0/0", fwd_wen, rs1_data);
    end
    step_to_bubble();
    tests_run++;
    if (rs1_data !== 32'd0 || instret !== 64'd7) begin
      failures++; $display("FAIL x0_write got=%08h/%0d exp=0/7", rs1_data, instret);
    end
    drive(0, 1, 5'd4, 32'h0000_AAAA, 1, F3_LH, 2'd1, 32'h500);
    tests_run++;
    if (fwd_wen !== 1'b0 || mis !== 1'b0) begin
      failures++; $display("FAIL bubble_comb got=%0b/%0b exp=0/0", fwd_wen, mis);
    end
    step_to_bubble();
    tests_run++;
    if (rs2_data !== 32'd0 || instret !== 64'd7 || mpc !== 32'h200) begin
      failures++; $display("FAIL bubble_state got=%08h/%0d/%08h exp=0/7/00000200", rs2_data, instret, mpc);
    end
  endtask

  task automatic test_wrap();
    @(negedge i_clk);
    force dut.instret_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.instret_reg;
    #1;
    tests_run++;
    if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      failures++; $display("FAIL wrap_preload got=%016h exp=ffffffffffffffff", instret);
    end
    drive(1, 0, 5'd0, 32'h0, 0, F3_LW, 2'd0, 32'h600);
    step_to_bubble();
    tests_run++;
    if (instret !== 64'd0) begin failures++; $display("FAIL wrap got=%016h exp=0", instret); end
  endtask

  task automatic test_reset_during_commit();
    rs1 = 5'd9; rs2 = 5'd3;
    drive(1, 1, 5'd9, 32'h55, 0, F3_LW, 2'd0, 32'h700);
    i_reset = 1'b1;
    step_to_bubble();
    i_reset = 1'b0;
    #1;
    tests_run++;
    if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
      failures++; $display("FAIL rst_commit_regs got=%08h/%08h exp=0/0", rs1_data, rs2_data);
    end
    rs1 = 5'd5; rs2 = 5'd7;
    #1;
    tests_run++;
    if (rs1_data !== 32'd0 || rs2_data !== 32'd0 || nb_instret !== 64'd0 || mpc !== 32'd0) begin
      failures++; $display("FAIL rst_commit_state got=%08h/%08h/%0d/%08h exp=0/0/0/0",
                           rs1_data, rs2_data, nb_instret, mpc);
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_ext();
    test_misalign();
    test_bypass();
    test_x0_and_bubble();
    test_wrap();
    test_reset_during_commit();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage of the RV32 pipeline. Sits directly downstream of the data-memory stage and consumes its WBACK_STATE register.
- Performs load-data extraction and sign/zero extension, then commits results into the 32x32 integer register file.
- Serves the two decode-stage read ports with write-through bypass, counts retired instructions, and flags misaligned loads.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural registers; x0 hardwired to zero.
- CNT_WIDTH, 64, width of the retired-instruction counter.
- BYPASS, 1, 1 = same-cycle write forwarded to read ports; 0 = read returns the old array value.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_valid  in  1  i_wback_state holds a real instruction (0 = bubble)
- i_wback_state  in  WBACK_STATE  pc, RegWrite, rd, final_out, MemToReg, funct3, byte_off
- i_rs1_addr  in  5  read port 1 address
- i_rs2_addr  in  5  read port 2 address
- o_rs1_data  out  XLEN  read port 1 data (combinational)
- o_rs2_data  out  XLEN  read port 2 data (combinational)
- o_fwd_wen  out  1  this-cycle commit, to the execute forwarding unit
- o_fwd_rd  out  5  commit destination
- o_fwd_data  out  XLEN  commit value (post-extension)
- o_instret  out  CNT_WIDTH  retired-instruction count
- o_misalign  out  1  one-cycle pulse: misaligned load detected
- o_misalign_pc  out  XLEN  pc of the last misaligned load

Behaviour:
- Reset, evaluated at posedge: all registers, o_instret, o_misalign and o_misalign_pc clear to 0. Reset overrides a simultaneous valid commit.
- Load extraction, when MemToReg=1. Data memory returns unshifted lanes with non-selected bytes already zero.
  - LB/LBU (funct3 0/4): byte final_out[8*byte_off +: 8], sign/zero-extended.
  - LH/LHU (1/5): half final_out[16*byte_off[1] +: 16], sign/zero-extended.
  - LW (2): final_out unchanged.
  - MemToReg=0: final_out passes through unchanged.
- Misalignment: LH/LHU with byte_off[0]=1, or LW with byte_off!=0.
  - No register write; no instret increment.
  - o_misalign=1 for that cycle; o_misalign_pc <= pc at the next edge, held until the next misalign.
  - Unknown funct3 with MemToReg=1 is treated as LW.
- Commit condition: i_valid & RegWrite & rd!=0 & !misalign.
  - Array write at posedge.
  - o_fwd_* are combinational from the current inputs; o_fwd_wen equals the commit condition.
- Reads:
  - Combinational from the array; address 0 always returns 0.
  - BYPASS=1 and the read address matches a committing rd: returns the new extended value in the same cycle.
  - Both ports may hit the same register simultaneously.
- o_instret: +1 per edge when i_valid & !misalign, independent of RegWrite (stores and branches count). Wraps at 2^CNT_WIDTH to 0.
- Bubbles (i_valid=0): no write, no count, no misalign, regardless of the other fields.
- Write to x0: silently dropped; the counter still increments.
- Latency: written value is visible to a decode read in the same cycle (bypass) or the next cycle (array).

Decomposition:
- PipelineReg package: WBACK_STATE extended with MemToReg (1), funct3 (3) and byte_off (2); the data-memory stage populates them.
- Package also holds the load funct3 constants F3_LB/LH/LW/LBU/LHU.
- Sub-module load_ext (combinational: funct3, byte_off, word -> value, misalign). Reused by formal checks.

Test Plan:
- Reset, then valid RegWrite rd=5, final_out=0xDEADBEEF, MemToReg=0 -> x5=0xDEADBEEF next cycle; o_instret=1.
- LB, byte_off=2, final_out=0x00800000 -> x7=0xFFFFFF80. Same inputs as LBU -> x7=0x00000080.
- LH, byte_off=1, pc=0x100 -> no write; o_misalign pulse; o_misalign_pc=0x100; instret unchanged.
- Commit x3=0x1234 while i_rs1_addr=3 and i_rs2_addr=3 -> both ports read 0x1234 in the same cycle (BYPASS=1); both read the old value with BYPASS=0.
- Write rd=0 value 0xFFFFFFFF -> read x0=0; instret increments. A bubble with RegWrite=1, rd=4 -> x4 unchanged, no count.
- Preload o_instret to 2^64-1 via force, then one retire -> wraps to 0. Reset asserted during a commit -> all registers zero.
